can_crc_engine: RTL and testbench

//  Parametrised serial CRC engine for the CAN controller: CRC-15 (CAN 2.0), CRC-17/21 (CAN FD).

---
 rtl/can_crc_pkg.sv | 17 +
 rtl/can_crc_engine_ser.sv | 34 +++
 rtl/can_crc_engine.sv | 108 ++++++++++
 tb/tb_can_crc_engine.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/can_crc_pkg.sv
// Shared constants and state encoding for the CAN CRC engine (CRC-15 / CRC-17 / CRC-21).
package can_crc_pkg;
  localparam logic [14:0] CRC15_POLY = 15'h4599;
  localparam logic [16:0] CRC17_POLY = 17'h1685B;
  localparam logic [20:0] CRC21_POLY = 21'h102899;

  // CAN FD seeds the register with only the MSB set
  localparam logic [16:0] CRC17_INIT = 17'h10000;
  localparam logic [20:0] CRC21_INIT = 21'h100000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2,
    SHIFT = 2'd3
  } crc_state_t;
endpackage

// File: rtl/can_crc_engine_ser.sv
// MSB-first CRC serialiser: shadow copy of the held CRC plus a bit down-counter.
module can_crc_ser #(
  parameter int CRC_W = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             active,
  input  logic [CRC_W-1:0] crc_in,
  output logic [CRC_W-1:0] shadow,
  output logic [CRC_W-1:0] crc_shifted,
  output logic             ser_bit,
  output logic             ser_last
);
  localparam int CW = (CRC_W > 1) ? $clog2(CRC_W) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      cnt    <= '0;
    end else if (load) begin
      shadow <= crc_in;
      cnt    <= CW'(CRC_W - 1);
    end else if (active && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign crc_shifted = {crc_in[CRC_W-2:0], 1'b0};
  assign ser_bit     = active ? crc_in[CRC_W-1] : 1'b0;
  assign ser_last    = active && (cnt == '0);
endmodule

// File: rtl/can_crc_engine.sv
// Serial CAN CRC engine: one destuffed bit per din_valid, frame delimited by start/finish.
// Define CAN_CRC_SER_EN to add the SHIFT state and MSB-first ser_* output.
module can_crc_engine
  import can_crc_pkg::*;
#(
  parameter int               CRC_W = 15,
  parameter logic [CRC_W-1:0] POLY  = 15'h4599,
  parameter logic [CRC_W-1:0] INIT  = '0,
  parameter int               CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             din,
  input  logic             din_valid,
  input  logic             finish,
`ifdef CAN_CRC_SER_EN
  input  logic             ser_req,
  output logic             ser_bit,
  output logic             ser_last,
`endif
  output logic [CRC_W-1:0] crc,
  output logic             crc_valid,
  output logic             crc_ok,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt
);
  crc_state_t       state, state_nxt;
  logic [CRC_W-1:0] crc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             take_bit;
  logic             fb;

  assign take_bit = (state == ACCUM) && din_valid && !start;
  assign fb       = crc[CRC_W-1] ^ din;

`ifdef CAN_CRC_SER_EN
  logic             ser_load;
  logic             ser_active;
  logic [CRC_W-1:0] shadow;
  logic [CRC_W-1:0] crc_shifted;

  assign ser_load   = (state == HOLD) && ser_req && !start;
  assign ser_active = (state == SHIFT);

  can_crc_ser #(.CRC_W(CRC_W)) u_ser (
    .clk         (clk),
    .rst         (rst),
    .load        (ser_load),
    .active      (ser_active),
    .crc_in      (crc),
    .shadow      (shadow),
    .crc_shifted (crc_shifted),
    .ser_bit     (ser_bit),
    .ser_last    (ser_last)
  );
`endif

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ACCUM;
    end else begin
      case (state)
        ACCUM: if (finish) state_nxt = HOLD;
`ifdef CAN_CRC_SER_EN
        HOLD:  if (ser_req) state_nxt = SHIFT;
        SHIFT: if (ser_last) state_nxt = HOLD;
`endif
        default: state_nxt = state;
      endcase
    end
  end

  // start wins over a coincident data bit; a bit alongside finish is still taken
  always_comb begin
    crc_nxt = crc;
    cnt_nxt = bit_cnt;
    if (start) begin
      crc_nxt = INIT;
      cnt_nxt = '0;
    end else if (take_bit) begin
      crc_nxt = {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      if (bit_cnt != '1) cnt_nxt = bit_cnt + 1'b1;
    end
`ifdef CAN_CRC_SER_EN
    else if (ser_active) begin
      crc_nxt = ser_last ? shadow : crc_shifted;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      crc     <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      crc     <= crc_nxt;
      bit_cnt <= cnt_nxt;
    end
  end

  assign crc_valid = (state == HOLD);
  assign crc_ok    = (state == HOLD) && (crc == '0);
  assign busy      = (state == ACCUM) || (state == SHIFT);
endmodule

// File: tb/tb_can_crc_engine.sv
// Self-checking bench for can_crc_engine (default CRC-15 build, optional serialiser checks).
module tb_can_crc_engine;
  logic        clk = 1'b0;
  logic        rst, start, din, din_valid, finish;
  logic [14:0] crc;
  logic        crc_valid, crc_ok, busy;
  logic [9:0]  bit_cnt;
`ifdef CAN_CRC_SER_EN
  logic        ser_req, ser_bit, ser_last;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [14:0] crc;
    logic [9:0]  cnt;
    logic        ok;
  } exp_t;

  exp_t        sb[$];
  bit          fbits[$];
  logic [14:0] m_crc;
  logic [9:0]  m_cnt;

  always #5 clk = ~clk;

  can_crc_engine dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .din       (din),
    .din_valid (din_valid),
    .finish    (finish),
`ifdef CAN_CRC_SER_EN
    .ser_req   (ser_req),
    .ser_bit   (ser_bit),
    .ser_last  (ser_last),
`endif
    .crc       (crc),
    .crc_valid (crc_valid),
    .crc_ok    (crc_ok),
    .busy      (busy),
    .bit_cnt   (bit_cnt)
  );

  // Reference: polynomial division with the explicit x^15 term in a 16-bit register
  function automatic logic [14:0] m_step(logic [14:0] c, bit b);
    logic [15:0] r;
    r = {c, 1'b0};
    if (r[15] ^ b) r = r ^ 16'hC599;
    return r[14:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (crc_valid) seen = 1'b1;
      else tick();
    end
  endtask

  // Drives start, the bits in fbits, then finish; pushes the model result
  task automatic drive_frame();
    exp_t e;
    start = 1'b1; tick(); start = 1'b0;
    m_crc = '0; m_cnt = '0;
    foreach (fbits[i]) begin
      din = fbits[i]; din_valid = 1'b1; tick();
      m_crc = m_step(m_crc, fbits[i]);
      if (m_cnt != 10'h3FF) m_cnt = m_cnt + 1'b1;
    end
    din_valid = 1'b0; din = 1'b0;
    finish = 1'b1; tick(); finish = 1'b0;
    e.crc = m_crc; e.cnt = m_cnt; e.ok = (m_crc == 15'h0);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; din = 0; din_valid = 0; finish = 0;
`ifdef CAN_CRC_SER_EN
    ser_req = 0;
`endif
    tick(); tick();
    total++; if (crc !== 15'h0)   begin bad++; $display("FAIL reset_crc got=%h want=0", crc); end
    total++; if (bit_cnt !== 10'h0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", bit_cnt); end
    total++; if (crc_valid !== 1'b0 || crc_ok !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_flags got v=%b ok=%b busy=%b want 0", crc_valid, crc_ok, busy);
    end
`ifdef CAN_CRC_SER_EN
    total++; if (ser_bit !== 1'b0 || ser_last !== 1'b0) begin
      bad++; $display("FAIL reset_ser got bit=%b last=%b want 0", ser_bit, ser_last);
    end
`endif
    rst = 1'b0; tick();
  endtask

  // Frame with a fixed known answer plus scoreboard check
  task automatic test_known(input string name, input logic [14:0] kcrc, input logic [9:0] kcnt, input logic kok);
    exp_t e; bit seen;
    drive_frame();
    wait_valid(seen);
    total++; if (!seen) begin bad++; $display("FAIL %s_timeout crc_valid never rose", name); end
    e = sb.pop_front();
    total++; if (crc !== e.crc || bit_cnt !== e.cnt || crc_ok !== e.ok) begin
      bad++; $display("FAIL %s_model got crc=%h cnt=%0d ok=%b want crc=%h cnt=%0d ok=%b",
                      name, crc, bit_cnt, crc_ok, e.crc, e.cnt, e.ok);
    end
    total++; if (crc !== kcrc || bit_cnt !== kcnt || crc_ok !== kok) begin
      bad++; $display("FAIL %s_const got crc=%h cnt=%0d ok=%b want crc=%h cnt=%0d ok=%b",
                      name, crc, bit_cnt, crc_ok, kcrc, kcnt, kok);
    end
  endtask

  task automatic test_collisions();
    // start with a bit: bit dropped; finish with a bit: bit counted
    start = 1'b1; din = 1'b1; din_valid = 1'b1; tick();
    start = 1'b0; din_valid = 1'b0;
    total++; if (bit_cnt !== 10'd0 || crc !== 15'h0 || busy !== 1'b1) begin
      bad++; $display("FAIL start_collision got cnt=%0d crc=%h busy=%b want 0/0/1", bit_cnt, crc, busy);
    end
    finish = 1'b1; din = 1'b1; din_valid = 1'b1; tick();
    finish = 1'b0; din_valid = 1'b0; din = 1'b0;
    total++; if (bit_cnt !== 10'd1 || crc !== 15'h4599 || crc_valid !== 1'b1) begin
      bad++; $display("FAIL finish_collision got cnt=%0d crc=%h v=%b want 1/4599/1", bit_cnt, crc, crc_valid);
    end
    // reset in the middle of a frame
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin din = 1'b1; din_valid = 1'b1; tick(); end
    din_valid = 1'b0;
    rst = 1'b1; #2;
    total++; if (crc !== 15'h0 || busy !== 1'b0 || bit_cnt !== 10'd0 || crc_valid !== 1'b0) begin
      bad++; $display("FAIL mid_reset got crc=%h busy=%b cnt=%0d v=%b want 0", crc, busy, bit_cnt, crc_valid);
    end
    tick(); rst = 1'b0; tick();
  endtask

  task automatic test_ignore();
    // IDLE straight after reset
    for (int i = 0; i < 20; i++) begin din = i[0]; din_valid = 1'b1; tick(); end
    din_valid = 1'b0;
    total++; if (crc !== 15'h0 || bit_cnt !== 10'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL ignore_idle got crc=%h cnt=%0d busy=%b want 0", crc, bit_cnt, busy);
    end
    // HOLD after a two-bit frame; finish in HOLD is also ignored
    fbits = '{1'b1, 1'b0};
    drive_frame();
    void'(sb.pop_front());
    for (int i = 0; i < 20; i++) begin din = ~i[0]; din_valid = 1'b1; finish = i[1]; tick(); end
    din_valid = 1'b0; finish = 1'b0;
    total++; if (crc !== 15'h4EAB || bit_cnt !== 10'd2 || crc_valid !== 1'b1) begin
      bad++; $display("FAIL ignore_hold got crc=%h cnt=%0d v=%b want 4eab/2/1", crc, bit_cnt, crc_valid);
    end
  endtask

  // Mid-frame restart discards the partial CRC; several random frames back to back
  task automatic test_back_to_back();
    exp_t e; bit seen;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 7; i++) begin din = 1'b1; din_valid = 1'b1; tick(); end
    din_valid = 1'b0;
    for (int f = 0; f < 6; f++) begin
      fbits.delete();
      for (int i = 0; i < int'($urandom_range(1, 40)); i++) fbits.push_back(1'($urandom));
      drive_frame();
      wait_valid(seen);
      e = sb.pop_front();
      total++; if (!seen || crc !== e.crc || bit_cnt !== e.cnt || crc_ok !== e.ok) begin
        bad++; $display("FAIL frame%0d got seen=%b crc=%h cnt=%0d ok=%b want crc=%h cnt=%0d ok=%b",
                        f, seen, crc, bit_cnt, crc_ok, e.crc, e.cnt, e.ok);
      end
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    fbits.delete();
    for (int i = 0; i < 1030; i++) fbits.push_back(1'($urandom));
    drive_frame();
    e = sb.pop_front();
    total++; if (bit_cnt !== 10'h3FF || e.cnt !== 10'h3FF) begin
      bad++; $display("FAIL saturate got cnt=%0d model=%0d want 1023", bit_cnt, e.cnt);
    end
    total++; if (crc !== e.crc) begin
      bad++; $display("FAIL saturate_crc got=%h want=%h", crc, e.crc);
    end
  endtask

`ifdef CAN_CRC_SER_EN
  task automatic test_serial();
    logic [14:0] pat;
    fbits = '{1'b1};
    drive_frame();
    void'(sb.pop_front());
    pat = 15'h4599;
    ser_req = 1'b1; tick(); ser_req = 1'b0;
    for (int i = 0; i < 15; i++) begin
      total++; if (ser_bit !== pat[14-i] || ser_last !== (i == 14) || crc_valid !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL ser_bit%0d got bit=%b last=%b v=%b busy=%b want bit=%b last=%b v=0 busy=1",
                        i, ser_bit, ser_last, crc_valid, busy, pat[14-i], (i == 14));
      end
      tick();
    end
    total++; if (crc !== 15'h4599 || crc_valid !== 1'b1 || busy !== 1'b0 || ser_bit !== 1'b0) begin
      bad++; $display("FAIL ser_restore got crc=%h v=%b busy=%b bit=%b want 4599/1/0/0", crc, crc_valid, busy, ser_bit);
    end
    // abort: start during SHIFT
    ser_req = 1'b1; tick(); ser_req = 1'b0; tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    total++; if (busy !== 1'b1 || crc !== 15'h0 || bit_cnt !== 10'd0 || ser_bit !== 1'b0) begin
      bad++; $display("FAIL ser_abort got busy=%b crc=%h cnt=%0d bit=%b want 1/0/0/0", busy, crc, bit_cnt, ser_bit);
    end
    finish = 1'b1; tick(); finish = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    fbits = '{1'b1};
    test_known("single_bit", 15'h4599, 10'd1, 1'b0);
    fbits = '{1'b1, 1'b0};
    test_known("two_bits", 15'h4EAB, 10'd2, 1'b0);
    fbits = '{1'b1, 1,0,0,0,1,0,1,1,0,0,1,1,0,0,1};
    test_known("residue", 15'h0, 10'd16, 1'b1);
    test_collisions();
    test_ignore();
    test_back_to_back();
    test_saturate();
`ifdef CAN_CRC_SER_EN
    test_serial();
`endif
    do_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
